alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 46 ++++
 rtl/alu_seq_regfile.sv | 38 +++
 rtl/alu_seq.sv | 175 +++++++++++++++++
 tb/tb_alu_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the alu_seq sequencer.
//   - opcode constants (ALU ops, LDI; every other code is a NOP)
//   - FSM state encoding
//   - instruction field positions: {op[9:6], rd[5:4], ra[3:2], rb[1:0]}
//   - helpers classifying an opcode
package alu_seq_pkg;

  localparam int DATA_W   = 4;
  localparam int NUM_REGS = 4;
  localparam int INSTR_W  = 10;

  localparam int OP_MSB = 9;
  localparam int OP_LSB = 6;
  localparam int RD_MSB = 5;
  localparam int RD_LSB = 4;
  localparam int RA_MSB = 3;
  localparam int RA_LSB = 2;
  localparam int RB_MSB = 1;
  localparam int RB_LSB = 0;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_PASS = 4'b1111;
  localparam logic [3:0] OP_LDI  = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  // Opcodes whose result comes from the external ALU and which update the flags.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_NOT) || (op == OP_PASS);
  endfunction

  // Opcodes that write rd (ALU ops and LDI); everything else is a NOP.
  function automatic logic writes_rd(input logic [3:0] op);
    return is_alu_op(op) || (op == OP_LDI);
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: 4 x 4-bit register file.
// Ports:
//   clk, rst           clock, synchronous active-high reset (clears all registers)
//   we, waddr, wdata   synchronous write port
//   raddr_a, rdata_a   combinational read port A
//   raddr_b, rdata_b   combinational read port B
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [1:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs_reg [NUM_REGS];

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          regs_reg[gi] <= '0;
        end else if (we && (waddr == 2'(gi))) begin
          regs_reg[gi] <= wdata;
        end
      end
    end
  endgenerate

  assign rdata_a = regs_reg[raddr_a];
  assign rdata_b = regs_reg[raddr_b];

endmodule

// File: rtl/alu_seq.sv
// alu_seq: three-state (IDLE -> EXEC -> WB) instruction sequencer driving an
// external combinational ALU.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   instr_valid, instr         instruction offer {op, rd, ra, rb}
//   instr_ready                high only in IDLE (and not in reset)
//   alu_a, alu_b, alu_op       ALU operands/opcode, non-zero only in EXEC
//   alu_result, alu_carry,     ALU response, sampled at the end of EXEC
//   alu_zero
//   done_valid, done_data      one-cycle writeback pulse and value written to rd
//   carry_flag, zero_flag      flags from the last ALU writeback
//   instr_count                (only with ALU_SEQ_STATS_EN) wrapping 8-bit count
//                              of done_valid pulses
// Optional feature macro: ALU_SEQ_STATS_EN
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [INSTR_W-1:0]  instr,
  output logic                instr_ready,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [3:0]          alu_op,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_carry,
  input  logic                alu_zero,
  output logic                done_valid,
  output logic [DATA_W-1:0]   done_data,
  output logic                carry_flag,
  output logic                zero_flag
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [7:0]          instr_count
`endif
);

  state_t             state_reg, state_next;
  logic [INSTR_W-1:0] instr_reg;
  logic [DATA_W-1:0]  result_reg;
  logic               carry_res_reg, zero_res_reg;
  logic               carry_flag_reg, zero_flag_reg;

  logic [3:0]         op;
  logic [1:0]         rd, ra, rb;
  logic               handshake;

  logic               rf_we;
  logic [1:0]         rf_raddr_a;
  logic [DATA_W-1:0]  rf_rdata_a, rf_rdata_b;

  assign op = instr_reg[OP_MSB:OP_LSB];
  assign rd = instr_reg[RD_MSB:RD_LSB];
  assign ra = instr_reg[RA_MSB:RA_LSB];
  assign rb = instr_reg[RB_MSB:RB_LSB];

  // instr_ready already excludes the reset cycle, so reset wins over a handshake.
  assign handshake = instr_valid && instr_ready;

  alu_seq_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rd),
    .wdata   (result_reg),
    .raddr_a (rf_raddr_a),
    .rdata_a (rf_rdata_a),
    .raddr_b (rb),
    .rdata_b (rf_rdata_b)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (handshake) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_WB;
      ST_WB:   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs. Port A reads ra in EXEC and rd in WB, so a NOP can report rd's
  // value without a third read port. All outputs are forced low in reset so an
  // operation caught in EXEC/WB never writes back or pulses done_valid.
  always_comb begin
    instr_ready = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = '0;
    done_valid  = 1'b0;
    done_data   = '0;
    rf_we       = 1'b0;
    rf_raddr_a  = ra;
    case (state_reg)
      ST_IDLE: instr_ready = 1'b1;
      ST_EXEC: begin
        alu_a  = rf_rdata_a;
        alu_b  = rf_rdata_b;
        alu_op = op;
      end
      ST_WB: begin
        rf_raddr_a = rd;
        done_valid = 1'b1;
        done_data  = writes_rd(op) ? result_reg : rf_rdata_a;
        rf_we      = writes_rd(op);
      end
      default: ;
    endcase
    if (rst) begin
      instr_ready = 1'b0;
      alu_a       = '0;
      alu_b       = '0;
      alu_op      = '0;
      done_valid  = 1'b0;
      done_data   = '0;
      rf_we       = 1'b0;
    end
  end

  // Datapath: the ALU response is captured at the end of EXEC because the ALU
  // inputs return to zero in WB; the register and flag writes happen at the
  // end of WB so that a reset during WB still cancels them.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_reg      <= '0;
      result_reg     <= '0;
      carry_res_reg  <= 1'b0;
      zero_res_reg   <= 1'b0;
      carry_flag_reg <= 1'b0;
      zero_flag_reg  <= 1'b0;
    end else begin
      if (handshake) begin
        instr_reg <= instr;
      end
      if (state_reg == ST_EXEC) begin
        result_reg    <= (op == OP_LDI) ? {ra, rb} : alu_result;
        carry_res_reg <= alu_carry;
        zero_res_reg  <= alu_zero;
      end
      if (done_valid && is_alu_op(op)) begin
        carry_flag_reg <= carry_res_reg;
        zero_flag_reg  <= zero_res_reg;
      end
    end
  end

  assign carry_flag = carry_flag_reg;
  assign zero_flag  = zero_flag_reg;

`ifdef ALU_SEQ_STATS_EN
  logic [7:0] instr_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_count_reg <= '0;
    end else if (done_valid) begin
      instr_count_reg <= instr_count_reg + 8'd1;
    end
  end

  assign instr_count = instr_count_reg;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq. Provides the external ALU,
// runs directed scenarios followed by random instructions, and compares the
// DUT against an instruction-level reference model.
module tb_alu_seq;

  logic       clk;
  logic       rst;
  logic       instr_valid;
  logic [9:0] instr;
  logic       instr_ready;
  logic [3:0] alu_a, alu_b, alu_op;
  logic [3:0] alu_result;
  logic       alu_carry, alu_zero;
  logic       done_valid;
  logic [3:0] done_data;
  logic       carry_flag, zero_flag;
`ifdef ALU_SEQ_STATS_EN
  logic [7:0] instr_count;
`endif

  int errors = 0;
  int checks = 0;
  int txn    = 0;

  // Reference model state.
  int m_regs [4];
  int m_c, m_z;
  int m_count;

  alu_seq dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_carry   (alu_carry),
    .alu_zero    (alu_zero),
    .done_valid  (done_valid),
    .done_data   (done_data),
    .carry_flag  (carry_flag),
    .zero_flag   (zero_flag)
`ifdef ALU_SEQ_STATS_EN
    ,
    .instr_count (instr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU. SUB reports a borrow in carry.
  always_comb begin
    logic [4:0] wide;
    wide = 5'd0;
    case (alu_op)
      4'b0000: wide = {1'b0, alu_a} + {1'b0, alu_b};
      4'b0001: wide = {1'b0, alu_a} - {1'b0, alu_b};
      4'b0010: wide = {1'b0, alu_a & alu_b};
      4'b0011: wide = {1'b0, alu_a | alu_b};
      4'b0100: wide = {1'b0, ~alu_a};
      4'b1111: wide = {1'b0, alu_a};
      default: wide = 5'd0;
    endcase
    alu_result = wide[3:0];
    alu_carry  = wide[4];
    alu_zero   = (wide[3:0] == 4'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_c = 0;
    m_z = 0;
    m_count = 0;
  endtask

  // Issue one instruction from an IDLE negedge and follow it through EXEC,
  // WB and back to IDLE. With hold set, instr_valid stays high until IDLE.
  task automatic send(input int op, input int rd, input int ra, input int rb, input bit hold);
    int waitc;
    int a, b, s, d, c, z;
    bit wr, fl;
    waitc = 0;
    while (instr_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (instr_ready !== 1'b1) begin
      check("ready_timeout", {31'd0, instr_ready}, 32'd1);
      return;
    end
    instr = {4'(op), 2'(rd), 2'(ra), 2'(rb)};
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) instr_valid = 1'b0;

    // Expected result from the instruction semantics.
    a = m_regs[ra];
    b = m_regs[rb];
    wr = 1; fl = 1; c = 0; d = 0;
    case (op)
      0:  begin s = a + b; d = s % 16; c = (s > 15) ? 1 : 0; end
      1:  begin d = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
      2:  d = a & b;
      3:  d = a | b;
      4:  d = 15 - a;
      15: d = a;
      8:  begin d = ra * 4 + rb; fl = 0; end
      default: begin d = m_regs[rd]; wr = 0; fl = 0; end
    endcase
    z = (d == 0) ? 1 : 0;

    @(negedge clk);  // EXEC
    check("exec_ready", {31'd0, instr_ready}, 32'd0);
    check("exec_done_valid", {31'd0, done_valid}, 32'd0);
    check("exec_alu_a", {28'd0, alu_a}, a);
    check("exec_alu_b", {28'd0, alu_b}, b);
    check("exec_alu_op", {28'd0, alu_op}, op);

    @(negedge clk);  // WB
    check("wb_done_valid", {31'd0, done_valid}, 32'd1);
    check("wb_done_data", {28'd0, done_data}, d);
    check("wb_alu_a_zero", {20'd0, alu_a, alu_b, alu_op}, 32'd0);
    check("wb_ready", {31'd0, instr_ready}, 32'd0);

    @(negedge clk);  // back in IDLE, writeback has happened
    if (wr) m_regs[rd] = d;
    if (fl) begin m_c = c; m_z = z; end
    m_count = (m_count + 1) % 256;
    check("idle_ready", {31'd0, instr_ready}, 32'd1);
    check("idle_done_valid", {31'd0, done_valid}, 32'd0);
    check("carry_flag", {31'd0, carry_flag}, m_c);
    check("zero_flag", {31'd0, zero_flag}, m_z);
`ifdef ALU_SEQ_STATS_EN
    check("instr_count", {24'd0, instr_count}, m_count);
`endif
    if (hold) instr_valid = 1'b0;
    txn++;
    $display("txn %0d op=%b rd=%0d ra=%0d rb=%0d done_data=%0d c=%0d z=%0d", txn, 4'(op), rd, ra, rb,
             done_data, carry_flag, zero_flag);
  endtask

  // Read every register back through NOPs (op 1010).
  task automatic verify_regs();
    for (int i = 0; i < 4; i++) send(10, i, 0, 0, 0);
  endtask

  initial begin
    int ops [8];
    ops = '{0, 1, 2, 3, 4, 15, 8, 10};
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, instr_ready}, 32'd0);
    check("rst_done_valid", {31'd0, done_valid}, 32'd0);
    check("rst_done_data", {28'd0, done_data}, 32'd0);
    check("rst_alu", {20'd0, alu_a, alu_b, alu_op}, 32'd0);
    check("rst_flags", {30'd0, carry_flag, zero_flag}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, instr_ready}, 32'd1);

    // LDI r0=3, LDI r1=2, ADD r2=r0+r1 -> 5
    send(8, 0, 0, 3, 0);
    send(8, 1, 0, 2, 0);
    send(0, 2, 0, 1, 0);
    // LDI r0=5, SUB r3=r0-r0 -> 0, zero
    send(8, 0, 1, 1, 0);
    send(1, 3, 0, 0, 0);
    // AND / OR / NOT
    send(8, 0, 2, 2, 0);
    send(8, 1, 3, 0, 0);
    send(2, 2, 0, 1, 0);
    send(3, 3, 0, 1, 0);
    send(8, 0, 3, 0, 0);
    send(4, 2, 0, 0, 0);
    // 15 + 1 -> 0 with carry and zero, then LDI keeps the flags
    send(8, 0, 3, 3, 0);
    send(8, 1, 0, 1, 0);
    send(0, 2, 0, 1, 0);
    send(8, 3, 1, 2, 0);
    // NOP with instr_valid held through EXEC/WB: single accept
    send(10, 1, 2, 3, 1);
    verify_regs();
    // rd aliasing ra/rb
    send(0, 0, 0, 0, 0);

    // Reset during EXEC of an ADD
    instr = {4'b0000, 2'd2, 2'd0, 2'd1};
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    check("rstexec_alu_a", {28'd0, alu_a}, m_regs[0]);
    rst = 1'b1;
    #1;
    check("rstexec_ready", {31'd0, instr_ready}, 32'd0);
    check("rstexec_alu", {20'd0, alu_a, alu_b, alu_op}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check("rstexec_done_valid", {31'd0, done_valid}, 32'd0);
    check("rstexec_ready_after", {31'd0, instr_ready}, 32'd1);
    check("rstexec_flags", {30'd0, carry_flag, zero_flag}, 32'd0);
    @(negedge clk);
    check("rstexec_no_wb", {31'd0, done_valid}, 32'd0);
    verify_regs();

    // Random instructions
    for (int n = 0; n < 60; n++) begin
      int op;
      op = ops[$urandom_range(0, 7)];
      if (op == 10) op = $urandom_range(5, 7) + ($urandom_range(0, 1) * 6);
      send(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
    end
    verify_regs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
